// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunked add/subtract unit: FSM state encoding
// and the sizing rule for the chunk counter.
package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A one-chunk configuration still needs a 1-bit counter to exist.
    function automatic int cnt_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_cpa.sv
// Combinational W-bit ripple-carry adder, time-multiplexed across the chunks
// of a wider operand; c_msb exposes the carry into the top bit for overflow.
module cpa_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co,
    output logic         c_msb
);

    logic [W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co    = c[W];
    assign c_msb = c[W-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: CHUNK bits per clock through one shared ripple
// adder, with a start/busy/done handshake and registered carry/overflow flags.
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);

    state_t state, next_state;

    logic [WIDTH-1:0] a_q, b_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [CHUNK-1:0] sum;
    logic             co, c_msb;

    // Operands shift right each cycle so the adder always sees the low chunk.
    cpa_chunk #(.W(CHUNK)) u_cpa (
        .x    (a_q[CHUNK-1:0]),
        .y    (b_q[CHUNK-1:0]),
        .ci   (carry),
        .sum  (sum),
        .co   (co),
        .c_msb(c_msb)
    );

    assign last = (cnt == CW'(NCHUNK - 1));
    assign busy = (state == ST_CALC);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = ST_CALC;
            ST_CALC: if (last)  next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Subtraction is folded in at acceptance: B is inverted and carry forced to 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                    end
                end
                ST_CALC: begin
                    a_q   <= a_q >> CHUNK;
                    b_q   <= b_q >> CHUNK;
                    carry <= co;
                    cnt   <= cnt + CW'(1);
                    for (int i = 0; i < NCHUNK; i++) begin
                        if (cnt == CW'(i)) s[i*CHUNK +: CHUNK] <= sum;
                    end
                    if (last) begin
                        cout <= co;
                        ovf  <= c_msb ^ co;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
